multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control unit for the 9-bit accumulator-style ISA. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back. Memory accesses wait on a ready handshake, and BRZ resolves on the zero flag. It sits between instruction fetch, the register file/ALU datapath and data memory, and also reports a retired-instruction count.

---
 rtl/ctrl_pkg.sv | 16 +
 rtl/multicycle_ctrl_if.sv | 16 +
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 71 +++++++
 tb/tb_multicycle_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/ALU/state/class types and halt encoding for multicycle_ctrl; CTRL_HALT_EN selects whether the all-ones instruction halts
package ctrl_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LDR, OP_STR, OP_BR, OP_BRZ} opcode_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LDR, C_STR, C_BR, C_BRZ, C_NOP, C_HALT} cls_t;
  localparam logic [8:0] HALT_INSTR = 9'h1FF;
`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: fetch/datapath/memory bundle (instr, instr_valid, zero, mem_ready in; strobes, busy, halted, retired out); master = environment, slave = controller
interface multicycle_ctrl_if #(parameter int INSTR_W = 9, parameter int CNT_W = 16);
  logic [INSTR_W-1:0] instr;
  logic instr_valid, zero, mem_ready;
  logic ir_load, reg_write, mem_read, mem_write, pc_write, branch_taken, busy, halted;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] retired;
  modport master(
    output instr, instr_valid, zero, mem_ready,
    input ir_load, alu_op, reg_write, mem_read, mem_write, pc_write, branch_taken, busy, halted, retired
  );
  modport slave(
    input instr, instr_valid, zero, mem_ready,
    output ir_load, alu_op, reg_write, mem_read, mem_write, pc_write, branch_taken, busy, halted, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: IR in -> instruction class (cls) and alu_op out; the HALT class exists only with CTRL_HALT_EN
module ctrl_decode import ctrl_pkg::*; #(
  parameter int INSTR_W = 9,
  parameter int OP_W = 3
) (
  input  logic [INSTR_W-1:0] ir,
  output cls_t               cls,
  output logic [2:0]         alu_op
);
  logic [OP_W-1:0] op;
  assign op = ir[INSTR_W-1 -: OP_W];
  always_comb begin
    cls = C_NOP;
    alu_op = ALU_ADD;
    if ((op >> 3) == '0)
      case (opcode_t'(op[2:0]))
        OP_LDR: cls = C_LDR;
        OP_STR: cls = C_STR;
        OP_BR: cls = C_BR;
        OP_BRZ: cls = (HALT_EN && &ir) ? C_HALT : C_BRZ;
        default: begin
          cls = C_ALU;
          alu_op = op[2:0];
        end
      endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer; ports clk, reset, bus (multicycle_ctrl_if.slave); CTRL_HALT_EN enables HALT
module multicycle_ctrl import ctrl_pkg::*; #(
  parameter int INSTR_W = 9,
  parameter int OP_W = 3,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  cls_t cls;
  logic [2:0] dec_alu;
  ctrl_decode #(.INSTR_W(INSTR_W), .OP_W(OP_W)) u_dec (.ir(ir_q), .cls(cls), .alu_op(dec_alu));
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      retired_q <= retired_d;
    end
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    bus.ir_load = 1'b0;
    bus.alu_op = ALU_ADD;
    bus.reg_write = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.branch_taken = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ir_load = bus.instr_valid;
        if (bus.instr_valid) begin
          ir_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = cls == C_HALT ? S_HALT : S_EXEC;
      S_EXEC: begin
        bus.alu_op = cls == C_ALU ? dec_alu : ALU_ADD;
        bus.reg_write = cls == C_ALU;
        bus.pc_write = cls != C_LDR && cls != C_STR;
        bus.branch_taken = cls == C_BR || (cls == C_BRZ && bus.zero);
        state_d = (cls == C_LDR || cls == C_STR) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        bus.mem_read = cls == C_LDR;
        bus.mem_write = cls == C_STR;
        bus.pc_write = bus.mem_ready && cls == C_STR;
        if (bus.mem_ready) state_d = cls == C_LDR ? S_WB : S_FETCH;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
    retired_d = retired_q + CNT_W'(bus.pc_write);
  end
  assign bus.busy = state_q != S_FETCH && state_q != S_HALT;
  assign bus.halted = HALT_EN && state_q == S_HALT;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a cycle-phase model
module tb_multicycle_ctrl;
  import ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.INSTR_W(9), .CNT_W(16)) bus();
  multicycle_ctrl_if #(.INSTR_W(9), .CNT_W(2)) bus2();
  multicycle_ctrl #(.INSTR_W(9), .OP_W(3), .CNT_W(16)) dut(.clk(clk), .reset(reset), .bus(bus));
  multicycle_ctrl #(.INSTR_W(9), .OP_W(3), .CNT_W(2)) dut2(.clk(clk), .reset(reset), .bus(bus2));
  assign bus2.instr = bus.instr;
  assign bus2.instr_valid = bus.instr_valid;
  assign bus2.zero = bus.zero;
  assign bus2.mem_ready = bus.mem_ready;
  int n_chk = 0, n_fail = 0;
  int k = 0, lat = 0, w = 0, mret = 0;
  bit mhalt = 0, minit = 0;
  logic [8:0] cur = '0;
  logic [31:0] a_irl, a_alu, a_rw, a_mr, a_mw, a_pcw, a_bt, a_busy, a_halt, a_ret, a_ret2;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic [8:0] ins, input logic z, input logic rdy);
    logic [2:0] op, e_alu;
    logic e_irl, e_rw, e_mr, e_mw, e_pcw, e_bt, e_busy, e_halt, lm, ls;
    @(posedge clk);
    #1;
    reset = r;
    bus.instr_valid = iv;
    bus.instr = ins;
    bus.zero = z;
    bus.mem_ready = rdy;
    @(negedge clk);
    op = cur[8:6];
    lm = op == 3'd4;
    ls = op == 3'd5;
    {e_irl, e_alu, e_rw, e_mr, e_mw, e_pcw, e_bt, e_busy, e_halt} = '0;
    if (mhalt) e_halt = 1'b1;
    else if (k == 0) e_irl = iv;
    else begin
      e_busy = 1'b1;
      if (k == 2) begin
        if (op < 3'd4) begin e_alu = op; e_rw = 1'b1; e_pcw = 1'b1; end
        else if (op == 3'd6) begin e_pcw = 1'b1; e_bt = 1'b1; end
        else if (op == 3'd7) begin e_pcw = 1'b1; e_bt = z; end
      end else if (k == 3) begin
        e_mr = lm;
        e_mw = ls;
        e_pcw = ls && rdy;
      end else if (k == 4) begin
        e_rw = 1'b1;
        e_pcw = 1'b1;
      end
    end
    a_irl = 32'(bus.ir_load); a_alu = 32'(bus.alu_op); a_rw = 32'(bus.reg_write);
    a_mr = 32'(bus.mem_read); a_mw = 32'(bus.mem_write); a_pcw = 32'(bus.pc_write);
    a_bt = 32'(bus.branch_taken); a_busy = 32'(bus.busy); a_halt = 32'(bus.halted);
    a_ret = 32'(bus.retired); a_ret2 = 32'(bus2.retired);
    if (k != 0) begin
      lat++;
      if (k == 3) w++;
    end
    if (minit) begin
      chk("outputs", 32'({bus.ir_load, bus.alu_op, bus.reg_write, bus.mem_read, bus.mem_write, bus.pc_write,
                          bus.branch_taken, bus.busy, bus.halted}),
          32'({e_irl, e_alu, e_rw, e_mr, e_mw, e_pcw, e_bt, e_busy, e_halt}));
      chk("retired", a_ret, 32'(mret[15:0]));
      chk("retired_w2", a_ret2, 32'(mret[1:0]));
      if (bus.pc_write && k != 0 && !r) chk("latency", 32'(lat), 32'(ls ? 3 + w : lm ? 4 + w : 3));
    end
    mret += int'(e_pcw);
    if (r) begin
      k = 0; mhalt = 0; mret = 0; minit = 1;
    end else if (!mhalt) begin
      if (k == 0) begin
        if (iv) begin k = 1; cur = ins; lat = 1; w = 0; end
      end else if (k == 1) begin
        if (HALT_EN && cur == HALT_INSTR) begin mhalt = 1; k = 0; end
        else k = 2;
      end else if (k == 2) k = (lm || ls) ? 3 : 0;
      else if (k == 3) begin
        if (rdy) k = lm ? 4 : 0;
      end else k = 0;
    end
  endtask
  initial begin
    int mrc;
    int exp2 [5] = '{1, 2, 3, 0, 1};
    logic [8:0] pins;
    bit have, acc, r, iv;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_busy", a_busy, 0); chk("rst_irl", a_irl, 0); chk("rst_ret", a_ret, 0); chk("rst_halt", a_halt, 0);
    step(0, 1, 9'b000_000001, 0, 0); chk("add_irl", a_irl, 1);
    step(0, 0, 9'b000_000001, 0, 0);
    step(0, 0, 9'b000_000001, 0, 0);
    chk("add_rw", a_rw, 1); chk("add_pcw", a_pcw, 1); chk("add_alu", a_alu, 32'(ALU_ADD));
    step(0, 0, 0, 0, 0); chk("add_ret", a_ret, 1);
    step(0, 1, 9'b100_000011, 0, 1);
    step(0, 0, 9'b100_000011, 0, 1);
    step(0, 0, 9'b100_000011, 0, 1); chk("ldr_exec_mr", a_mr, 0);
    mrc = 0;
    step(0, 0, 9'b100_000011, 0, 0); mrc += int'(a_mr);
    step(0, 0, 9'b100_000011, 0, 0); mrc += int'(a_mr);
    step(0, 0, 9'b100_000011, 0, 1); mrc += int'(a_mr);
    chk("ldr_mr_cycles", 32'(mrc), 3);
    step(0, 0, 0, 0, 0); chk("ldr_wb_rw", a_rw, 1); chk("ldr_wb_pcw", a_pcw, 1); chk("ldr_wb_mr", a_mr, 0);
    step(0, 1, 9'b111_000001, 0, 0);
    step(0, 0, 9'b111_000001, 0, 0);
    step(0, 0, 9'b111_000001, 1, 0); chk("brz1_bt", a_bt, 1); chk("brz1_pcw", a_pcw, 1);
    step(0, 1, 9'b111_000001, 1, 0);
    step(0, 0, 9'b111_000001, 1, 0);
    step(0, 0, 9'b111_000001, 0, 0); chk("brz0_bt", a_bt, 0); chk("brz0_pcw", a_pcw, 1);
    step(0, 0, 0, 0, 0); chk("brz_ret", a_ret, 4);
    step(0, 1, 9'b101_000000, 0, 0);
    step(0, 0, 9'b101_000000, 0, 0);
    step(0, 0, 9'b101_000000, 0, 0);
    step(0, 0, 9'b101_000000, 0, 0); chk("str_mw1", a_mw, 1);
    step(1, 0, 9'b101_000000, 0, 0); chk("str_mw2", a_mw, 1);
    step(0, 0, 9'b101_000000, 0, 1);
    chk("str_rst_mw", a_mw, 0); chk("str_rst_busy", a_busy, 0); chk("str_rst_ret", a_ret, 0);
    step(0, 1, HALT_INSTR, 1, 0);
    step(0, 0, HALT_INSTR, 1, 0);
    step(0, 0, HALT_INSTR, 1, 0);
    chk("halt_flag", a_halt, 32'(HALT_EN)); chk("halt_pcw", a_pcw, 32'(!HALT_EN)); chk("halt_bt", a_bt, 32'(!HALT_EN));
    step(0, 1, 9'b000_000001, 1, 0);
    chk("halt_irl", a_irl, 32'(!HALT_EN)); chk("halt_ret", a_ret, HALT_EN ? 0 : 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 9'b001_000010, 0, 0);
      step(0, 0, 9'b001_000010, 0, 0);
      step(0, 0, 9'b001_000010, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("ret2_wrap", a_ret2, 32'(exp2[i]));
    end
    step(1, 0, 0, 0, 0);
    have = 0;
    pins = '0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(99) == 0;
      if (!have) begin
        pins = $urandom_range(49) == 0 ? HALT_INSTR : 9'($urandom);
        have = 1;
      end
      iv = $urandom_range(9) < 7;
      acc = !r && !mhalt && k == 0 && iv;
      step(r, iv, pins, 1'($urandom_range(1)), $urandom_range(9) < 4);
      if (acc) have = 0;
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
